// File: rtl/alu_4bit.sv
// alu_4bit: registered 4-bit ALU. Fourteen result buses plus y/Cout
// chosen by S. Inputs A, B, S; every output is a flop, 1-cycle latency.
module alu_4bit (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic [3:0] S,
  output logic [3:0] Add,
  output logic [3:0] Diff,
  output logic [3:0] Twos,
  output logic [3:0] Inc,
  output logic [3:0] Dec,
  output logic [3:0] Bit_and,
  output logic [3:0] Bit_or,
  output logic [3:0] Bit_xor,
  output logic [3:0] Ones,
  output logic [3:0] Sh_left,
  output logic [3:0] Sh_right,
  output logic [3:0] Ar_right,
  output logic [3:0] Ro_left,
  output logic [3:0] Ro_right,
  output logic [3:0] y,
  output logic       Cout
);

  // 5-bit sums keep the carry out in bit 4
  logic [4:0] add5;
  logic [4:0] sub5;
  logic [4:0] inc5;
  logic [4:0] dec5;

  assign add5 = {1'b0, A} + {1'b0, B};
  assign sub5 = {1'b0, A} + {1'b0, ~B} + 5'd1;
  assign inc5 = {1'b0, A} + 5'd1;
  assign dec5 = {1'b0, A} + 5'b01111;

  logic [3:0] add_d,  add_q;
  logic [3:0] diff_d, diff_q;
  logic [3:0] twos_d, twos_q;
  logic [3:0] inc_d,  inc_q;
  logic [3:0] dec_d,  dec_q;
  logic [3:0] and_d,  and_q;
  logic [3:0] or_d,   or_q;
  logic [3:0] xor_d,  xor_q;
  logic [3:0] ones_d, ones_q;
  logic [3:0] shl_d,  shl_q;
  logic [3:0] shr_d,  shr_q;
  logic [3:0] asr_d,  asr_q;
  logic [3:0] rol_d,  rol_q;
  logic [3:0] ror_d,  ror_q;
  logic [3:0] y_d,    y_q;
  logic       cout_d, cout_q;

  assign add_d  = add5[3:0];
  assign diff_d = sub5[3:0];
  assign twos_d = ~A + 4'd1;
  assign inc_d  = inc5[3:0];
  assign dec_d  = dec5[3:0];
  assign and_d  = A & B;
  assign or_d   = A | B;
  assign xor_d  = A ^ B;
  assign ones_d = ~A;
  assign shl_d  = {A[2:0], 1'b0};
  assign shr_d  = {1'b0, A[3:1]};
  assign asr_d  = {A[3], A[3:1]};
  assign rol_d  = {A[2:0], A[3]};
  assign ror_d  = {A[0], A[3:1]};

  always_comb begin
    y_d    = 4'd0;
    cout_d = 1'b0;
    case (S)
      4'b0000: begin
        y_d    = add_d;
        cout_d = add5[4];
      end
      4'b0001: begin
        y_d    = diff_d;
        cout_d = sub5[4];
      end
      4'b0010: y_d = twos_d;
      4'b0011: begin
        y_d    = inc_d;
        cout_d = inc5[4];
      end
      4'b0100: begin
        y_d    = dec_d;
        cout_d = dec5[4];
      end
      4'b0101: y_d = and_d;
      4'b0110: y_d = or_d;
      4'b0111: y_d = xor_d;
      4'b1000: y_d = ones_d;
      4'b1001: y_d = shl_d;
      4'b1010: y_d = shr_d;
      4'b1011: y_d = asr_d;
      4'b1100: y_d = rol_d;
      4'b1101: y_d = ror_d;
      default: begin
        y_d    = 4'd0;
        cout_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      add_q  <= '0;
      diff_q <= '0;
      twos_q <= '0;
      inc_q  <= '0;
      dec_q  <= '0;
      and_q  <= '0;
      or_q   <= '0;
      xor_q  <= '0;
      ones_q <= '0;
      shl_q  <= '0;
      shr_q  <= '0;
      asr_q  <= '0;
      rol_q  <= '0;
      ror_q  <= '0;
      y_q    <= '0;
      cout_q <= 1'b0;
    end else begin
      add_q  <= add_d;
      diff_q <= diff_d;
      twos_q <= twos_d;
      inc_q  <= inc_d;
      dec_q  <= dec_d;
      and_q  <= and_d;
      or_q   <= or_d;
      xor_q  <= xor_d;
      ones_q <= ones_d;
      shl_q  <= shl_d;
      shr_q  <= shr_d;
      asr_q  <= asr_d;
      rol_q  <= rol_d;
      ror_q  <= ror_d;
      y_q    <= y_d;
      cout_q <= cout_d;
    end
  end

  assign Add      = add_q;
  assign Diff     = diff_q;
  assign Twos     = twos_q;
  assign Inc      = inc_q;
  assign Dec      = dec_q;
  assign Bit_and  = and_q;
  assign Bit_or   = or_q;
  assign Bit_xor  = xor_q;
  assign Ones     = ones_q;
  assign Sh_left  = shl_q;
  assign Sh_right = shr_q;
  assign Ar_right = asr_q;
  assign Ro_left  = rol_q;
  assign Ro_right = ror_q;
  assign y        = y_q;
  assign Cout     = cout_q;

endmodule

// File: tb/tb_alu_4bit.sv
// tb_alu_4bit: directed vectors plus a full A/B/S sweep
// against an integer reference model, with an async reset pulse.
module tb_alu_4bit;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] A, B, S;
  logic [3:0] Add, Diff, Twos, Inc, Dec;
  logic [3:0] Bit_and, Bit_or, Bit_xor, Ones;
  logic [3:0] Sh_left, Sh_right, Ar_right;
  logic [3:0] Ro_left, Ro_right, y;
  logic       Cout;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_4bit dut (
    .clk(clk), .rst(rst), .A(A), .B(B), .S(S),
    .Add(Add), .Diff(Diff), .Twos(Twos),
    .Inc(Inc), .Dec(Dec),
    .Bit_and(Bit_and), .Bit_or(Bit_or),
    .Bit_xor(Bit_xor), .Ones(Ones),
    .Sh_left(Sh_left), .Sh_right(Sh_right),
    .Ar_right(Ar_right), .Ro_left(Ro_left),
    .Ro_right(Ro_right), .y(y), .Cout(Cout)
  );

  task automatic chk(input string tag,
                     input logic [3:0] obs,
                     input logic [3:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".Add"}, Add, 4'd0);
    chk({tag, ".Diff"}, Diff, 4'd0);
    chk({tag, ".Twos"}, Twos, 4'd0);
    chk({tag, ".Ones"}, Ones, 4'd0);
    chk({tag, ".Dec"}, Dec, 4'd0);
    chk({tag, ".Ror"}, Ro_right, 4'd0);
    chk({tag, ".y"}, y, 4'd0);
    chk({tag, ".Cout"}, {3'b0, Cout}, 4'd0);
  endtask

  // Integer reference model, checks all outputs for (a,b,s)
  task automatic chk_model(input int a, input int b,
                           input int s);
    int e[16];
    int ey, ec;
    string t;
    t = $sformatf("sw a=%0d b=%0d s=%0d", a, b, s);
    e[0]  = (a + b) % 16;
    e[1]  = (a - b + 16) % 16;
    e[2]  = (16 - a) % 16;
    e[3]  = (a + 1) % 16;
    e[4]  = (a + 15) % 16;
    e[5]  = a & b;
    e[6]  = a | b;
    e[7]  = a ^ b;
    e[8]  = 15 - a;
    e[9]  = (a * 2) % 16;
    e[10] = a / 2;
    e[11] = a / 2 + ((a >= 8) ? 8 : 0);
    e[12] = (a * 2) % 16 + a / 8;
    e[13] = a / 2 + (a % 2) * 8;
    e[14] = 0;
    e[15] = 0;
    ey = e[s];
    ec = 0;
    if (s == 0) ec = (a + b > 15) ? 1 : 0;
    if (s == 1) ec = (a >= b) ? 1 : 0;
    if (s == 3) ec = (a == 15) ? 1 : 0;
    if (s == 4) ec = (a != 0) ? 1 : 0;
    chk({t, " Add"}, Add, 4'(e[0]));
    chk({t, " Diff"}, Diff, 4'(e[1]));
    chk({t, " Twos"}, Twos, 4'(e[2]));
    chk({t, " Inc"}, Inc, 4'(e[3]));
    chk({t, " Dec"}, Dec, 4'(e[4]));
    chk({t, " And"}, Bit_and, 4'(e[5]));
    chk({t, " Or"}, Bit_or, 4'(e[6]));
    chk({t, " Xor"}, Bit_xor, 4'(e[7]));
    chk({t, " Ones"}, Ones, 4'(e[8]));
    chk({t, " Shl"}, Sh_left, 4'(e[9]));
    chk({t, " Shr"}, Sh_right, 4'(e[10]));
    chk({t, " Asr"}, Ar_right, 4'(e[11]));
    chk({t, " Rol"}, Ro_left, 4'(e[12]));
    chk({t, " Ror"}, Ro_right, 4'(e[13]));
    chk({t, " y"}, y, 4'(ey));
    chk({t, " Cout"}, {3'b0, Cout}, 4'(ec));
  endtask

  initial begin
    rst = 1'b1;
    A = 4'($urandom_range(15));
    B = 4'($urandom_range(15));
    S = 4'($urandom_range(15));
    #1;
    chk_zero("rst_async");
    step();
    step();
    chk_zero("rst_held");

    rst = 1'b0;
    A = 4'b1001;
    B = 4'b0001;
    S = 4'b0000;
    step();
    chk("d1.Add", Add, 4'b1010);
    chk("d1.Diff", Diff, 4'b1000);
    chk("d1.Twos", Twos, 4'b0111);
    chk("d1.Inc", Inc, 4'b1010);
    chk("d1.Dec", Dec, 4'b1000);
    chk("d1.And", Bit_and, 4'b0001);
    chk("d1.Or", Bit_or, 4'b1001);
    chk("d1.Xor", Bit_xor, 4'b1000);
    chk("d1.Ones", Ones, 4'b0110);
    chk("d1.Shl", Sh_left, 4'b0010);
    chk("d1.Shr", Sh_right, 4'b0100);
    chk("d1.Asr", Ar_right, 4'b1100);
    chk("d1.Rol", Ro_left, 4'b0011);
    chk("d1.Ror", Ro_right, 4'b1100);
    chk("d1.y", y, 4'b1010);
    chk("d1.Cout", {3'b0, Cout}, 4'd0);

    S = 4'b1100;
    #1;
    chk("lat.y_hold", y, 4'b1010);
    step();
    chk("s12.y", y, 4'b0011);
    chk("s12.Cout", {3'b0, Cout}, 4'd0);
    chk("s12.Add", Add, 4'b1010);
    S = 4'b1001;
    step();
    chk("s9.y", y, 4'b0010);
    chk("s9.Cout", {3'b0, Cout}, 4'd0);

    A = 4'b1111;
    B = 4'b0001;
    S = 4'b0000;
    step();
    chk("f_add.y", y, 4'b0000);
    chk("f_add.Cout", {3'b0, Cout}, 4'd1);
    S = 4'b0011;
    step();
    chk("f_inc.y", y, 4'b0000);
    chk("f_inc.Cout", {3'b0, Cout}, 4'd1);

    A = 4'b0000;
    B = 4'b0001;
    S = 4'b0001;
    step();
    chk("z_sub.y", y, 4'b1111);
    chk("z_sub.Cout", {3'b0, Cout}, 4'd0);
    S = 4'b0100;
    step();
    chk("z_dec.y", y, 4'b1111);
    chk("z_dec.Cout", {3'b0, Cout}, 4'd0);
    S = 4'b1110;
    step();
    chk("z_s14.y", y, 4'b0000);
    chk("z_s14.Cout", {3'b0, Cout}, 4'd0);

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int s = 0; s < 16; s++) begin
          A = 4'(a);
          B = 4'(b);
          S = 4'(s);
          step();
          chk_model(a, b, s);
          if (a == 8 && b == 3 && s == 5) begin
            rst = 1'b1;
            #1;
            chk_zero("rst_mid");
            rst = 1'b0;
          end
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_4bit.md
# alu_4bit

Registered 4-bit arithmetic/logic unit. Computes fourteen fixed operations on 4-bit operands A and B in parallel and presents every result on its own output bus, plus a 4-bit result y selected by the 4-bit opcode S, with a carry/borrow flag Cout. All outputs are registered, giving one-cycle latency. The block sits in the datapath as a general-purpose combinational-compute stage followed by an output register.

## Interface
- No parameters; data width is fixed at 4 bits.
- clk  input  1  rising-edge clock for all output registers.
- rst  input  1  asynchronous, active-high reset.
- A  input  4  operand A (unsigned; two's-complement where noted).
- B  input  4  operand B.
- S  input  4  opcode selecting y and Cout.
- Add  output  4  A + B (low 4 bits).
- Diff  output  4  A − B (mod 16).
- Twos  output  4  two's complement of A (−A mod 16).
- Inc  output  4  A + 1 (mod 16).
- Dec  output  4  A − 1 (mod 16).
- Bit_and  output  4  A & B.
- Bit_or  output  4  A | B.
- Bit_xor  output  4  A ^ B.
- Ones  output  4  ~A.
- Sh_left  output  4  A logical shift left 1, LSB filled 0.
- Sh_right  output  4  A logical shift right 1, MSB filled 0.
- Ar_right  output  4  A arithmetic shift right 1, MSB replicated.
- Ro_left  output  4  A rotate left 1 ({A[2:0],A[3]}).
- Ro_right  output  4  A rotate right 1 ({A[0],A[3:1]}).
- y  output  4  result selected by S.
- Cout  output  1  carry/no-borrow flag for the selected operation.

## Operation
- All fourteen operation buses are computed from A and B every cycle, independent of S.
- Opcode map for y: 0000 Add, 0001 Diff, 0010 Twos, 0011 Inc, 0100 Dec, 0101 Bit_and, 0110 Bit_or, 0111 Bit_xor, 1000 Ones, 1001 Sh_left, 1010 Sh_right, 1011 Ar_right, 1100 Ro_left, 1101 Ro_right; 1110 and 1111 give y = 0000.
- Cout by opcode: 0000 carry out of 5-bit A+B; 0001 carry out of A + ~B + 1 (1 = no borrow, A ≥ B); 0011 carry out of A+1 (1 only when A = 1111); 0100 carry out of A + 1111 (0 only when A = 0000); all other opcodes Cout = 0.
- All arithmetic is modulo 16; no overflow flag.
- S containing X/Z: y and Cout are don't-care; the individual operation buses remain valid.

## Timing
- Every output (all fourteen buses, y, Cout) is a flip-flop updated on rising clk from the A/B/S values present just before that edge; latency exactly 1 cycle, throughput 1 per cycle.
- rst high asynchronously forces every output to 0 immediately, independent of clk; outputs stay 0 while rst is high.
- First update after reset deassertion occurs on the first rising clk edge with rst low.
- Reset asserted mid-stream discards the pending result; no state other than output registers exists.
- Changing S alone changes y/Cout on the next edge; operation buses are unaffected.

## Test plan
- Reset: assert rst with random A/B/S and no clk edge -> all outputs 0 immediately; hold rst across edges -> still 0.
- A=1001, B=0001, one edge -> Add 1010, Diff 1000, Twos 0111, Inc 1010, Dec 1000, Bit_and 0001, Bit_or 1001, Bit_xor 1000, Ones 0110, Sh_left 0010, Sh_right 0100, Ar_right 1100, Ro_left 0011, Ro_right 1100.
- Same A/B, S sequenced 0000, 1100, 1001 one per cycle -> y 1010/Cout 0, then y 0011/Cout 0, then y 0010/Cout 0, each one cycle after S applied.
- A=1111, B=0001, S=0000 -> y 0000, Cout 1; S=0011 -> y 0000, Cout 1.
- A=0000, B=0001, S=0001 -> y 1111, Cout 0; S=0100 -> y 1111, Cout 0; S=1110 -> y 0000, Cout 0.
- Sweep all 256 A/B pairs × 16 opcodes against a reference model, checking 1-cycle latency, with one asynchronous rst pulse mid-sweep clearing outputs.
